// File: rtl/i2c_apb_sequencer_if.sv
// Interface bundling the sequencer's client-side request/data streams and its 8-bit APB
// master port.
//   master modport : the sequencer (drives APB request signals, client ready/valid outputs)
//   slave modport  : client logic plus the APB register port of the I2C controller
// Client side: req_* (transaction request), wd_* (write bytes in), rd_* (read bytes out),
//              done_o/err_o (completion report).
// APB side   : PSEL, PENABLE, PWRITE, PADDR, PWDATA out; PRDATA, PREADY in.
interface i2c_apb_sequencer_if;
  logic       req_valid_i;
  logic       req_ready_o;
  logic       req_rw_i;
  logic [6:0] req_addr_i;
  logic [3:0] req_len_i;
  logic       wd_valid_i;
  logic [7:0] wd_data_i;
  logic       wd_ready_o;
  logic       rd_valid_o;
  logic [7:0] rd_data_o;
  logic       done_o;
  logic       err_o;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;

  modport master (
    input  req_valid_i, req_rw_i, req_addr_i, req_len_i, wd_valid_i, wd_data_i,
    input  PRDATA, PREADY,
    output req_ready_o, wd_ready_o, rd_valid_o, rd_data_o, done_o, err_o,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req_valid_i, req_rw_i, req_addr_i, req_len_i, wd_valid_i, wd_data_i,
    output PRDATA, PREADY,
    input  req_ready_o, wd_ready_o, rd_valid_o, rd_data_o, done_o, err_o,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/i2c_apb_sequencer.sv
// APB master that runs complete I2C transactions on the I2C controller's register port:
// programs slave address and length, starts the transfer, polls STATUS, moves TX/RX bytes
// and reports completion (done_o, with err_o on NACK or poll timeout).
// Ports:
//   PCLK    : clock, all logic on the rising edge
//   PRESETn : synchronous active-low reset
//   bus     : i2c_apb_sequencer_if.master (client request/data streams + APB master)
// Optional feature macro I2C_SEQ_PRESCALE_INIT_EN: when defined, the FSM starts in an INIT
// state after reset and writes PRESCALE_VAL to REG_PRESCALE once before accepting requests.
// All outputs are registered.
module i2c_apb_sequencer #(
  parameter logic [7:0] REG_CMD      = 8'h00,
  parameter logic [7:0] REG_SADDR    = 8'h01,
  parameter logic [7:0] REG_TX       = 8'h02,
  parameter logic [7:0] REG_RX       = 8'h03,
  parameter logic [7:0] REG_STATUS   = 8'h04,
  parameter logic [7:0] REG_LEN      = 8'h05,
`ifdef I2C_SEQ_PRESCALE_INIT_EN
  parameter logic [7:0] REG_PRESCALE = 8'h06,
  parameter logic [7:0] PRESCALE_VAL = 8'd4,
`endif
  parameter int unsigned POLL_TIMEOUT = 256
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  i2c_apb_sequencer_if.master        bus
);

  localparam int unsigned PollW = $clog2(POLL_TIMEOUT + 1);
  localparam logic [PollW-1:0] PollLast = PollW'(POLL_TIMEOUT - 1);

  typedef enum logic [3:0] {
    StIdle, StInit, StWSaddr, StWLen, StWStart, StPTx, StWaitWd, StWTx,
    StPRx, StRRx, StPDone, StAbort, StFin
  } state_e;

`ifdef I2C_SEQ_PRESCALE_INIT_EN
  localparam state_e ResetState = StInit;
`else
  localparam state_e ResetState = StIdle;
`endif

  // One pending APB operation; sel=1 means a transfer is in SETUP or ACCESS.
  typedef struct packed {
    logic       sel;
    logic       write;
    logic [7:0] addr;
    logic [7:0] data;
  } op_t;

  localparam op_t NoOp = '0;

  function automatic op_t wr_op(input logic [7:0] a, input logic [7:0] d);
    return '{sel: 1'b1, write: 1'b1, addr: a, data: d};
  endfunction

  function automatic op_t rd_op(input logic [7:0] a);
    return '{sel: 1'b1, write: 1'b0, addr: a, data: 8'h00};
  endfunction

  state_e           state_q;
  op_t              op_q;
  logic             penable_q;
  logic             rw_q;
  logic [3:0]       cnt_q;
  logic [PollW-1:0] poll_q;
  logic             req_ready_q, wd_ready_q, rd_valid_q, done_q, err_q;
  logic [7:0]       rd_data_q;

  logic xfer_done;
  logic poll_last;
  assign xfer_done = op_q.sel & penable_q & bus.PREADY;
  assign poll_last = (poll_q == PollLast);

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q     <= ResetState;
      op_q        <= NoOp;
      penable_q   <= 1'b0;
      rw_q        <= 1'b0;
      cnt_q       <= '0;
      poll_q      <= '0;
      req_ready_q <= 1'b0;
      wd_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;

      // SETUP always lasts one cycle; a completed ACCESS returns to SETUP if the FSM keeps
      // or replaces op_q with another operation (back-to-back), otherwise op_q is cleared.
      if (op_q.sel && !penable_q) begin
        penable_q <= 1'b1;
      end else if (xfer_done) begin
        penable_q <= 1'b0;
      end

      unique case (state_q)
`ifdef I2C_SEQ_PRESCALE_INIT_EN
        StInit: begin
          if (!op_q.sel) begin
            op_q <= wr_op(REG_PRESCALE, PRESCALE_VAL);
          end else if (xfer_done) begin
            op_q        <= NoOp;
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
`endif
        StIdle: begin
          req_ready_q <= 1'b1;
          if (bus.req_valid_i && req_ready_q) begin
            req_ready_q <= 1'b0;
            rw_q        <= bus.req_rw_i;
            cnt_q       <= bus.req_len_i;
            op_q        <= wr_op(REG_SADDR, {bus.req_addr_i, bus.req_rw_i});
            state_q     <= StWSaddr;
          end
        end
        StWSaddr: if (xfer_done) begin
          op_q    <= wr_op(REG_LEN, {4'h0, cnt_q});
          state_q <= StWLen;
        end
        StWLen: if (xfer_done) begin
          op_q    <= wr_op(REG_CMD, 8'h01);
          state_q <= StWStart;
        end
        StWStart: if (xfer_done) begin
          poll_q <= '0;
          op_q   <= rd_op(REG_STATUS);
          if (cnt_q == 4'd0)   state_q <= StPDone;  // address probe
          else if (rw_q)       state_q <= StPRx;
          else                 state_q <= StPTx;
        end
        StPTx: if (xfer_done) begin
          if (!bus.PRDATA[1]) begin
            op_q       <= NoOp;
            wd_ready_q <= 1'b1;
            state_q    <= StWaitWd;
          end else if (poll_last) begin
            op_q    <= wr_op(REG_CMD, 8'h02);
            state_q <= StAbort;
          end else begin
            poll_q <= poll_q + 1'b1;  // op_q unchanged: re-issue the STATUS read
          end
        end
        StWaitWd: if (bus.wd_valid_i) begin
          wd_ready_q <= 1'b0;
          op_q       <= wr_op(REG_TX, bus.wd_data_i);
          state_q    <= StWTx;
        end
        StWTx: if (xfer_done) begin
          cnt_q   <= cnt_q - 4'd1;
          poll_q  <= '0;
          op_q    <= rd_op(REG_STATUS);
          state_q <= (cnt_q == 4'd1) ? StPDone : StPTx;
        end
        StPRx: if (xfer_done) begin
          if (bus.PRDATA[3]) begin
            op_q    <= NoOp;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= StFin;
          end else if (!bus.PRDATA[2]) begin
            op_q    <= rd_op(REG_RX);
            state_q <= StRRx;
          end else if (poll_last) begin
            op_q    <= wr_op(REG_CMD, 8'h02);
            state_q <= StAbort;
          end else begin
            poll_q <= poll_q + 1'b1;
          end
        end
        StRRx: if (xfer_done) begin
          rd_valid_q <= 1'b1;
          rd_data_q  <= bus.PRDATA;
          cnt_q      <= cnt_q - 4'd1;
          poll_q     <= '0;
          op_q       <= rd_op(REG_STATUS);
          state_q    <= (cnt_q == 4'd1) ? StPDone : StPRx;
        end
        StPDone: if (xfer_done) begin
          if (!bus.PRDATA[0]) begin
            op_q    <= NoOp;
            done_q  <= 1'b1;
            err_q   <= bus.PRDATA[3];
            state_q <= StFin;
          end else if (poll_last) begin
            op_q    <= wr_op(REG_CMD, 8'h02);
            state_q <= StAbort;
          end else begin
            poll_q <= poll_q + 1'b1;
          end
        end
        StAbort: if (xfer_done) begin
          op_q    <= NoOp;
          done_q  <= 1'b1;
          err_q   <= 1'b1;
          state_q <= StFin;
        end
        StFin: begin
          req_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: begin
          op_q    <= NoOp;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.PSEL        = op_q.sel;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = op_q.write;
  assign bus.PADDR       = op_q.addr;
  assign bus.PWDATA      = op_q.data;
  assign bus.req_ready_o = req_ready_q;
  assign bus.wd_ready_o  = wd_ready_q;
  assign bus.rd_valid_o  = rd_valid_q;
  assign bus.rd_data_o   = rd_data_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;

endmodule

// File: doc/i2c_apb_sequencer.md
Name: i2c_apb_sequencer

Overview:
APB master that drives the I2C controller's 8-bit APB register port (top_level) so client logic can run whole I2C transactions without touching registers. Takes one transaction request (slave address, direction, byte count) with streaming data, programs the register file, starts the transfer, polls status, moves TX/RX bytes, then reports completion or error. Sits between system logic and the I2C core in the PCLK domain.

Parameters:
REG_CMD, 8'h00, command register address (bit0 START, bit1 ABORT)
REG_SADDR, 8'h01, slave address register ({addr[6:0], rw})
REG_TX, 8'h02, TX data register
REG_RX, 8'h03, RX data register
REG_STATUS, 8'h04, status register (bit0 BUSY, bit1 TX_FULL, bit2 RX_EMPTY, bit3 NACK)
REG_LEN, 8'h05, byte count register
REG_PRESCALE, 8'h06, SCL prescale register (optional feature only)
PRESCALE_VAL, 8'd4, prescale value written at init
POLL_TIMEOUT, 256, max STATUS reads per poll loop before abort

Ports:
PCLK  in  1  clock; all logic on rising edge
PRESETn  in  1  reset; synchronous, active-low
req_valid_i  in  1  transaction request valid
req_ready_o  out  1  sequencer idle, accepts request
req_rw_i  in  1  1 = read, 0 = write
req_addr_i  in  7  I2C slave address
req_len_i  in  4  data bytes, 0..15
wd_valid_i  in  1  write byte valid
wd_data_i  in  8  write byte
wd_ready_o  out  1  write byte consumed this cycle
rd_valid_o  out  1  one-cycle pulse, read byte valid
rd_data_o  out  8  read byte
done_o  out  1  one-cycle pulse, transaction finished
err_o  out  1  valid with done_o: NACK or timeout
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  8  APB address
PWDATA  out  8  APB write data
PRDATA  in  8  APB read data
PREADY  in  1  APB ready

Behaviour:
- Reset (PRESETn low at a PCLK edge): all outputs 0, FSM to IDLE (or INIT with feature), counters cleared; abandons any APB transfer, PSEL low the cycle after the reset edge.
- APB op: SETUP cycle (PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA stable), then ACCESS (PENABLE=1) held until PREADY=1; PRDATA sampled on that edge; PSEL/PENABLE drop next cycle unless a back-to-back SETUP follows. Min 2 cycles per op; signals stable during wait states.
- req_ready_o=1 only in IDLE; handshake on req_valid_i & req_ready_o; request fields latched.
- FSM: IDLE -> W_SADDR (write {addr,rw}) -> W_LEN (write len) -> W_START (write CMD=8'h01) -> data phase -> P_DONE -> FIN -> IDLE.
- Write data phase per byte: P_TX (read STATUS until TX_FULL=0) -> WAIT_WD (wd_ready_o=1 while waiting; byte taken when wd_valid_i=1, wd_ready_o pulses exactly one cycle) -> W_TX (write byte).
- Read data phase per byte: P_RX (read STATUS until RX_EMPTY=0; NACK=1 here -> FIN with err) -> R_RX (read RX) -> rd_valid_o pulse with rd_data_o = PRDATA the cycle after PREADY.
- len=0: skip data phase (address probe).
- P_DONE: read STATUS until BUSY=0; err = NACK bit.
- Any poll loop reaching POLL_TIMEOUT reads without exit -> ABORT (write CMD=8'h02) -> FIN with err=1; remaining write bytes are not consumed.
- FIN: done_o=1 for one cycle, err_o valid same cycle, else 0. IDLE next cycle.
- Byte counter 4-bit, counts down from len; no wrap; poll counter saturates, reset at each new poll loop.
- req_valid_i ignored outside IDLE; wd_valid_i ignored outside WAIT_WD.

Optional Feature:
I2C_SEQ_PRESCALE_INIT_EN: defined -> after reset FSM enters INIT, writes PRESCALE_VAL to REG_PRESCALE once, then IDLE; req_ready_o stays 0 until that write completes. Undefined -> no INIT, req_ready_o=1 first cycle after reset release, REG_PRESCALE never accessed.

Test Plan:
- Reset with PREADY=1: all outputs 0; feature on -> first APB op write 8'h06<=8'h04, req_ready_o rises after it; off -> req_ready_o=1 immediately, no APB traffic.
- Write addr 0x50 len 2 bytes 0x11,0x22, STATUS=0x00 -> APB writes 01<=A0, 05<=02, 00<=01, STATUS read, 02<=11, STATUS read, 02<=22, STATUS read, done_o=1 err_o=0.
- Read addr 0x50 len 3, RX returns 0x5A,0x5B,0x5C -> 01<=A1, three rd_valid_o pulses with those values in order, done_o err_o=0.
- STATUS=0x08 in P_DONE -> done_o=1 err_o=1; len=0 -> no TX/RX access, single done_o.
- STATUS stuck 0x01 -> exactly POLL_TIMEOUT STATUS reads, then 00<=02, done_o with err_o=1.
- PREADY low 3 cycles per access -> ACCESS held 4 cycles, signals stable; PRESETn low mid-ACCESS -> PSEL=0 next cycle, FSM IDLE/INIT.
